// File: rtl/sc_threshold_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : sc_threshold_filter_if
// Description : Sample/handshake bundle between the comparator-side consumer
//               and the threshold persistence filter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sc_threshold_filter_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   SC_THRESHFILTER_enable_InHigh;
  logic                   SC_THRESHFILTER_greaterthan_InLow;
  logic                   SC_THRESHFILTER_clear_InHigh;
  logic                   SC_THRESHFILTER_ack_InHigh;
  logic                   SC_THRESHFILTER_over_OutHigh;
  logic                   SC_THRESHFILTER_rise_OutHigh;
  logic                   SC_THRESHFILTER_eventvalid_OutHigh;
  logic                   SC_THRESHFILTER_overrun_OutHigh;
  logic [COUNT_WIDTH-1:0] SC_THRESHFILTER_eventcount_OutBUS;

  // Consumer side: drives samples and handshakes, observes filter state.
  modport master (
    output SC_THRESHFILTER_enable_InHigh,
    output SC_THRESHFILTER_greaterthan_InLow,
    output SC_THRESHFILTER_clear_InHigh,
    output SC_THRESHFILTER_ack_InHigh,
    input  SC_THRESHFILTER_over_OutHigh,
    input  SC_THRESHFILTER_rise_OutHigh,
    input  SC_THRESHFILTER_eventvalid_OutHigh,
    input  SC_THRESHFILTER_overrun_OutHigh,
    input  SC_THRESHFILTER_eventcount_OutBUS
  );

  // Filter side.
  modport slave (
    input  SC_THRESHFILTER_enable_InHigh,
    input  SC_THRESHFILTER_greaterthan_InLow,
    input  SC_THRESHFILTER_clear_InHigh,
    input  SC_THRESHFILTER_ack_InHigh,
    output SC_THRESHFILTER_over_OutHigh,
    output SC_THRESHFILTER_rise_OutHigh,
    output SC_THRESHFILTER_eventvalid_OutHigh,
    output SC_THRESHFILTER_overrun_OutHigh,
    output SC_THRESHFILTER_eventcount_OutBUS
  );
endinterface
`default_nettype wire

// File: rtl/sc_threshold_filter.sv
`default_nettype none
// ============================================================================
// Module      : sc_threshold_filter
// Description : Persistence filter on an active-low greater-than flag. OVER is
//               entered/left only after FILTER_DEPTH consecutive agreeing
//               samples; each entry produces a pulse, a pending-event flag
//               with ack, a sticky overrun and a saturating event count.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_threshold_filter #(
  parameter int FILTER_DEPTH = 4,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                 SC_THRESHFILTER_CLOCK_50,
  input  logic                 SC_THRESHFILTER_RESET_InLow,
  sc_threshold_filter_if.slave bus
);

  localparam int                     CNT_W     = $clog2(FILTER_DEPTH + 1);
  localparam logic [CNT_W-1:0]       DEPTH_C   = CNT_W'(FILTER_DEPTH);
  localparam logic [CNT_W-1:0]       ONE_C     = CNT_W'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_BELOW  = 2'd0,
    ST_ARMING = 2'd1,
    ST_OVER   = 2'd2,
    ST_DISARM = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   entry_d;
  logic                   over_q, rise_q, evvalid_q, overrun_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic en, hit, clr, ack;
  assign en  = bus.SC_THRESHFILTER_enable_InHigh;
  assign hit = ~bus.SC_THRESHFILTER_greaterthan_InLow;
  assign clr = bus.SC_THRESHFILTER_clear_InHigh;
  assign ack = bus.SC_THRESHFILTER_ack_InHigh;

  // Next-state and run-count logic; entry_d marks a BELOW/ARMING -> OVER move.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    entry_d = 1'b0;
    cnt_inc = cnt_q + ONE_C;
    if (en) begin
      case (state_q)
        ST_BELOW: begin
          if (hit) begin
            if (DEPTH_C == ONE_C) begin
              state_d = ST_OVER;
              cnt_d   = '0;
              entry_d = 1'b1;
            end else begin
              state_d = ST_ARMING;
              cnt_d   = ONE_C;
            end
          end
        end
        ST_ARMING: begin
          if (hit) begin
            if (cnt_inc == DEPTH_C) begin
              state_d = ST_OVER;
              cnt_d   = '0;
              entry_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_BELOW;
            cnt_d   = '0;
          end
        end
        ST_OVER: begin
          if (!hit) begin
            if (DEPTH_C == ONE_C) begin
              state_d = ST_BELOW;
              cnt_d   = '0;
            end else begin
              state_d = ST_DISARM;
              cnt_d   = ONE_C;
            end
          end
        end
        ST_DISARM: begin
          if (!hit) begin
            if (cnt_inc == DEPTH_C) begin
              state_d = ST_BELOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Returning from DISARM is not a new entry.
            state_d = ST_OVER;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // FSM state register with registered filtered level and entry pulse.
  always_ff @(posedge SC_THRESHFILTER_CLOCK_50) begin
    if (!SC_THRESHFILTER_RESET_InLow) begin
      state_q <= ST_BELOW;
      cnt_q   <= '0;
      over_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      over_q  <= (state_d == ST_OVER) || (state_d == ST_DISARM);
      rise_q  <= entry_d;
    end
  end

  // Event recorder: pending flag with ack, sticky overrun, saturating count.
  always_ff @(posedge SC_THRESHFILTER_CLOCK_50) begin
    if (!SC_THRESHFILTER_RESET_InLow) begin
      evvalid_q <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      // A new entry wins over a same-edge ack so the fresh event is not lost.
      if (entry_d) begin
        evvalid_q <= 1'b1;
      end else if (ack) begin
        evvalid_q <= 1'b0;
      end
      if (clr) begin
        overrun_q <= 1'b0;
      end else if (entry_d && evvalid_q && !ack) begin
        overrun_q <= 1'b1;
      end
      // Clear drops any same-edge increment.
      if (clr) begin
        count_q <= '0;
      end else if (entry_d && (count_q != COUNT_MAX)) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.SC_THRESHFILTER_over_OutHigh       = over_q;
  assign bus.SC_THRESHFILTER_rise_OutHigh       = rise_q;
  assign bus.SC_THRESHFILTER_eventvalid_OutHigh = evvalid_q;
  assign bus.SC_THRESHFILTER_overrun_OutHigh    = overrun_q;
  assign bus.SC_THRESHFILTER_eventcount_OutBUS  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_threshold_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_threshold_filter
// Description : Directed self-checking bench for sc_threshold_filter.
//               dut_a: DEPTH=4/CW=8, dut_b: DEPTH=4/CW=2 (same stimulus),
//               dut_c: DEPTH=1/CW=8 (own sample inputs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_threshold_filter;

  logic clk = 1'b0;
  logic rst_n;
  logic en, gt, clr, ack;
  logic en_c, gt_c;
  logic flag;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sc_threshold_filter_if #(.COUNT_WIDTH(8)) bus_a ();
  sc_threshold_filter_if #(.COUNT_WIDTH(2)) bus_b ();
  sc_threshold_filter_if #(.COUNT_WIDTH(8)) bus_c ();

  assign bus_a.SC_THRESHFILTER_enable_InHigh     = en;
  assign bus_a.SC_THRESHFILTER_greaterthan_InLow = gt;
  assign bus_a.SC_THRESHFILTER_clear_InHigh      = clr;
  assign bus_a.SC_THRESHFILTER_ack_InHigh        = ack;
  assign bus_b.SC_THRESHFILTER_enable_InHigh     = en;
  assign bus_b.SC_THRESHFILTER_greaterthan_InLow = gt;
  assign bus_b.SC_THRESHFILTER_clear_InHigh      = clr;
  assign bus_b.SC_THRESHFILTER_ack_InHigh        = ack;
  assign bus_c.SC_THRESHFILTER_enable_InHigh     = en_c;
  assign bus_c.SC_THRESHFILTER_greaterthan_InLow = gt_c;
  assign bus_c.SC_THRESHFILTER_clear_InHigh      = 1'b0;
  assign bus_c.SC_THRESHFILTER_ack_InHigh        = 1'b0;

  sc_threshold_filter #(.FILTER_DEPTH(4), .COUNT_WIDTH(8)) dut_a (
    .SC_THRESHFILTER_CLOCK_50    (clk),
    .SC_THRESHFILTER_RESET_InLow (rst_n),
    .bus                         (bus_a)
  );
  sc_threshold_filter #(.FILTER_DEPTH(4), .COUNT_WIDTH(2)) dut_b (
    .SC_THRESHFILTER_CLOCK_50    (clk),
    .SC_THRESHFILTER_RESET_InLow (rst_n),
    .bus                         (bus_b)
  );
  sc_threshold_filter #(.FILTER_DEPTH(1), .COUNT_WIDTH(8)) dut_c (
    .SC_THRESHFILTER_CLOCK_50    (clk),
    .SC_THRESHFILTER_RESET_InLow (rst_n),
    .bus                         (bus_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one sample, clock it in, and settle 1 ns past the edge.
  task automatic step(input logic e, input logic g, input logic c, input logic a);
    en  = e;
    gt  = g;
    clr = c;
    ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic g);
    repeat (n) step(1'b1, g, 1'b0, 1'b0);
  endtask

  task automatic step_c(input logic e, input logic g);
    en_c = e;
    gt_c = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_c  = 1'b0;
    gt_c  = 1'b1;
    // Reset must override hits on the sample input.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_over",  bus_a.SC_THRESHFILTER_over_OutHigh, 0);
    check("rst_rise",  bus_a.SC_THRESHFILTER_rise_OutHigh, 0);
    check("rst_ev",    bus_a.SC_THRESHFILTER_eventvalid_OutHigh, 0);
    check("rst_ovr",   bus_a.SC_THRESHFILTER_overrun_OutHigh, 0);
    check("rst_cnt",   bus_a.SC_THRESHFILTER_eventcount_OutBUS, 0);
    check("rst_c_over", bus_c.SC_THRESHFILTER_over_OutHigh, 0);
    rst_n = 1'b1;

    // Idle: misses only.
    flag = 1'b0;
    repeat (20) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      flag = flag | bus_a.SC_THRESHFILTER_over_OutHigh | bus_a.SC_THRESHFILTER_rise_OutHigh
           | bus_a.SC_THRESHFILTER_eventvalid_OutHigh | bus_a.SC_THRESHFILTER_overrun_OutHigh
           | (bus_a.SC_THRESHFILTER_eventcount_OutBUS != 8'd0);
    end
    check("idle_quiet", flag, 0);

    // Interrupted run, then four hits.
    run(3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run(3, 1'b0);
    check("arm_3hit_over", bus_a.SC_THRESHFILTER_over_OutHigh, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("entry_over", bus_a.SC_THRESHFILTER_over_OutHigh, 1);
    check("entry_rise", bus_a.SC_THRESHFILTER_rise_OutHigh, 1);
    check("entry_ev",   bus_a.SC_THRESHFILTER_eventvalid_OutHigh, 1);
    check("entry_cnt",  bus_a.SC_THRESHFILTER_eventcount_OutBUS, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rise_1cyc",  bus_a.SC_THRESHFILTER_rise_OutHigh, 0);

    // Disarm, return, then release.
    run(2, 1'b1);
    check("disarm_hold", bus_a.SC_THRESHFILTER_over_OutHigh, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("return_norise", bus_a.SC_THRESHFILTER_rise_OutHigh, 0);
    run(3, 1'b1);
    check("rel_3miss", bus_a.SC_THRESHFILTER_over_OutHigh, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rel_4miss", bus_a.SC_THRESHFILTER_over_OutHigh, 0);
    check("no_2nd_entry", bus_a.SC_THRESHFILTER_eventcount_OutBUS, 1);

    // Enable low holds progress; second entry without ack -> overrun.
    run(3, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("en_hold", bus_a.SC_THRESHFILTER_over_OutHigh, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("e2_over", bus_a.SC_THRESHFILTER_over_OutHigh, 1);
    check("e2_ev",   bus_a.SC_THRESHFILTER_eventvalid_OutHigh, 1);
    check("e2_ovr",  bus_a.SC_THRESHFILTER_overrun_OutHigh, 1);
    check("e2_cnt",  bus_a.SC_THRESHFILTER_eventcount_OutBUS, 2);
    check("e2_cnt_b", bus_b.SC_THRESHFILTER_eventcount_OutBUS, 2);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("ack_ev",  bus_a.SC_THRESHFILTER_eventvalid_OutHigh, 0);
    check("ack_ovr", bus_a.SC_THRESHFILTER_overrun_OutHigh, 1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("clr_cnt",   bus_a.SC_THRESHFILTER_eventcount_OutBUS, 0);
    check("clr_ovr",   bus_a.SC_THRESHFILTER_overrun_OutHigh, 0);
    check("clr_cnt_b", bus_b.SC_THRESHFILTER_eventcount_OutBUS, 0);
    check("clr_over",  bus_a.SC_THRESHFILTER_over_OutHigh, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("ack_idle_ev", bus_a.SC_THRESHFILTER_eventvalid_OutHigh, 0);
    run(4, 1'b1);
    check("rel_again", bus_a.SC_THRESHFILTER_over_OutHigh, 0);

    // Five entries: 8-bit counts 5, 2-bit saturates at 3.
    repeat (5) begin
      run(4, 1'b0);
      run(4, 1'b1);
    end
    check("sat_a",   bus_a.SC_THRESHFILTER_eventcount_OutBUS, 5);
    check("sat_b",   bus_b.SC_THRESHFILTER_eventcount_OutBUS, 3);
    check("sat_ovr", bus_a.SC_THRESHFILTER_overrun_OutHigh, 1);

    // Entry on the same edge as clear: increment dropped.
    run(3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("eclr_cnt_a", bus_a.SC_THRESHFILTER_eventcount_OutBUS, 0);
    check("eclr_cnt_b", bus_b.SC_THRESHFILTER_eventcount_OutBUS, 0);
    check("eclr_ovr",   bus_a.SC_THRESHFILTER_overrun_OutHigh, 0);
    check("eclr_rise",  bus_a.SC_THRESHFILTER_rise_OutHigh, 1);
    check("eclr_ev",    bus_a.SC_THRESHFILTER_eventvalid_OutHigh, 1);
    run(4, 1'b1);

    // Entry on the same edge as ack: event stays pending, no overrun.
    run(3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("eack_ev",  bus_a.SC_THRESHFILTER_eventvalid_OutHigh, 1);
    check("eack_ovr", bus_a.SC_THRESHFILTER_overrun_OutHigh, 0);
    check("eack_cnt", bus_b.SC_THRESHFILTER_eventcount_OutBUS, 1);
    run(4, 1'b1);

    // Reset mid-arming (cnt=2) with an event pending.
    run(2, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("mrst_over", bus_a.SC_THRESHFILTER_over_OutHigh, 0);
    check("mrst_ev",   bus_a.SC_THRESHFILTER_eventvalid_OutHigh, 0);
    check("mrst_cnt",  bus_a.SC_THRESHFILTER_eventcount_OutBUS, 0);
    run(2, 1'b0);
    check("fresh_2hit", bus_a.SC_THRESHFILTER_over_OutHigh, 0);
    run(1, 1'b0);
    check("fresh_3hit", bus_a.SC_THRESHFILTER_over_OutHigh, 0);
    run(1, 1'b0);
    check("fresh_4hit", bus_a.SC_THRESHFILTER_over_OutHigh, 1);
    check("fresh_cnt",  bus_a.SC_THRESHFILTER_eventcount_OutBUS, 1);

    // DEPTH=1: single sample enters and leaves.
    step_c(1'b1, 1'b0);
    check("d1_over", bus_c.SC_THRESHFILTER_over_OutHigh, 1);
    check("d1_rise", bus_c.SC_THRESHFILTER_rise_OutHigh, 1);
    check("d1_cnt",  bus_c.SC_THRESHFILTER_eventcount_OutBUS, 1);
    step_c(1'b1, 1'b0);
    check("d1_rise_1cyc", bus_c.SC_THRESHFILTER_rise_OutHigh, 0);
    step_c(1'b1, 1'b1);
    check("d1_release", bus_c.SC_THRESHFILTER_over_OutHigh, 0);
    step_c(1'b1, 1'b0);
    check("d1_rise2", bus_c.SC_THRESHFILTER_rise_OutHigh, 1);
    check("d1_cnt2",  bus_c.SC_THRESHFILTER_eventcount_OutBUS, 2);
    check("d1_ovr",   bus_c.SC_THRESHFILTER_overrun_OutHigh, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
